// File: rtl/calc_pkg.sv
// Shared calculator types, limits and the two's-complement helper used by the
// number-entry front end.
package calc_pkg;

  localparam int unsigned VAL_W       = 8;
  localparam int unsigned CAND_W      = 12;
  localparam int unsigned DIGIT_W     = 4;
  localparam int unsigned COUNT_W     = 2;
  localparam int unsigned MAX_POS     = 127;
  localparam int unsigned MAX_NEG_MAG = 128;
  localparam int unsigned MAX_DIGITS  = 3;
  localparam int unsigned BCD_MAX     = 9;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ENTRY = 2'd1,
    DONE  = 2'd2
  } entry_state_e;

  // One-cycle press pulses from the four debounced buttons.
  typedef struct packed {
    logic clear;
    logic enter;
    logic sign;
    logic digit;
  } key_pulse_t;

  function automatic logic [VAL_W-1:0] to_twos(input logic [VAL_W-1:0] mag,
                                                input logic             neg);
    return neg ? (~mag + VAL_W'(1)) : mag;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchroniser, stability counter and press-edge pulse for one
// active-low pushbutton.
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic reset,
  input  logic key_n,
  output logic press
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_a;
  logic             sync_b;
  logic             stable;
  logic             stable_d;
  logic             armed;
  logic [CNT_W-1:0] cnt;

  // Synchroniser flops reset to the pressed level so a key held through reset
  // is never mistaken for a fresh press; armed only sets once a release is seen.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_a   <= 1'b0;
      sync_b   <= 1'b0;
      stable   <= 1'b1;
      stable_d <= 1'b1;
      armed    <= 1'b0;
      cnt      <= '0;
      press    <= 1'b0;
    end else begin
      sync_a   <= key_n;
      sync_b   <= sync_a;
      stable_d <= stable;
      if (sync_b != stable) begin
        if (cnt == CNT_MAX) begin
          stable <= sync_b;
          cnt    <= '0;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end else begin
        cnt <= '0;
      end
      if (sync_b && stable) begin
        armed <= 1'b1;
      end
      press <= armed & stable_d & ~stable;
    end
  end

endmodule

// File: rtl/num_entry.sv
// Signed 8-bit operand entry from BCD switches and pushbuttons, with a
// valid/ready hand-off of the committed value.
module num_entry
  import calc_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [DIGIT_W-1:0] sw_digit,
  input  logic               key_digit_n,
  input  logic               key_sign_n,
  input  logic               key_enter_n,
  input  logic               key_clear_n,
  output logic [VAL_W-1:0]   entry_value,
  output logic               entry_active,
  output logic [COUNT_W-1:0] digit_count,
  output logic               err,
  output logic [VAL_W-1:0]   out_value,
  output logic               out_valid,
  input  logic               out_ready
);

  logic p_digit;
  logic p_sign;
  logic p_enter;
  logic p_clear;
  key_pulse_t pulse;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_digit (
    .clk(clk), .reset(reset), .key_n(key_digit_n), .press(p_digit));
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_sign (
    .clk(clk), .reset(reset), .key_n(key_sign_n), .press(p_sign));
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_enter (
    .clk(clk), .reset(reset), .key_n(key_enter_n), .press(p_enter));
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clear (
    .clk(clk), .reset(reset), .key_n(key_clear_n), .press(p_clear));

  assign pulse = {p_clear, p_enter, p_sign, p_digit};

  entry_state_e       state_q;
  entry_state_e       state_d;
  logic [VAL_W-1:0]   mag_q;
  logic [VAL_W-1:0]   mag_d;
  logic               neg_q;
  logic               neg_d;
  logic [COUNT_W-1:0] cnt_d;
  logic               err_d;
  logic [VAL_W-1:0]   out_value_d;
  logic               out_valid_d;
  logic [CAND_W-1:0]  cand;
  logic [CAND_W-1:0]  lim;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and next datapath values; a single pulse acts per cycle,
  // clear first, then enter, sign, digit.
  always_comb begin
    state_d     = state_q;
    mag_d       = mag_q;
    neg_d       = neg_q;
    cnt_d       = digit_count;
    err_d       = err;
    out_value_d = out_value;
    out_valid_d = out_valid;
    cand        = CAND_W'(mag_q) * CAND_W'(10) + CAND_W'(sw_digit);
    lim         = neg_q ? CAND_W'(MAX_NEG_MAG) : CAND_W'(MAX_POS);

    if (pulse.clear) begin
      state_d     = IDLE;
      mag_d       = '0;
      neg_d       = 1'b0;
      cnt_d       = '0;
      err_d       = 1'b0;
      out_valid_d = 1'b0;
    end else begin
      case (state_q)
        IDLE, ENTRY: begin
          if (pulse.enter) begin
            if (state_q == ENTRY) begin
              out_value_d = to_twos(mag_q, neg_q);
              out_valid_d = 1'b1;
              state_d     = DONE;
            end
          end else if (pulse.sign) begin
            // -128 has no positive counterpart in 8 bits
            if (neg_q && (mag_q == VAL_W'(MAX_NEG_MAG))) begin
              err_d = 1'b1;
            end else begin
              neg_d = ~neg_q;
            end
          end else if (pulse.digit) begin
            if ((sw_digit > DIGIT_W'(BCD_MAX)) ||
                (digit_count == COUNT_W'(MAX_DIGITS)) ||
                (cand > lim)) begin
              err_d = 1'b1;
            end else begin
              mag_d   = cand[VAL_W-1:0];
              cnt_d   = digit_count + COUNT_W'(1);
              state_d = ENTRY;
            end
          end
        end
        DONE: begin
          if (out_valid && out_ready) begin
            out_valid_d = 1'b0;
            mag_d       = '0;
            neg_d       = 1'b0;
            cnt_d       = '0;
            err_d       = 1'b0;
            state_d     = IDLE;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // Datapath and output registers; display outputs follow the next-state values.
  always_ff @(posedge clk) begin
    if (reset) begin
      mag_q        <= '0;
      neg_q        <= 1'b0;
      digit_count  <= '0;
      err          <= 1'b0;
      out_value    <= '0;
      out_valid    <= 1'b0;
      entry_value  <= '0;
      entry_active <= 1'b0;
    end else begin
      mag_q        <= mag_d;
      neg_q        <= neg_d;
      digit_count  <= cnt_d;
      err          <= err_d;
      out_value    <= out_value_d;
      out_valid    <= out_valid_d;
      entry_value  <= to_twos(mag_d, neg_d);
      entry_active <= (cnt_d != '0);
    end
  end

endmodule

// File: tb/tb_num_entry.sv
// Directed bench for num_entry with a short debounce window.
module tb_num_entry;

  localparam logic [3:0] K_DIGIT = 4'b0001;
  localparam logic [3:0] K_SIGN  = 4'b0010;
  localparam logic [3:0] K_ENTER = 4'b0100;
  localparam logic [3:0] K_CLEAR = 4'b1000;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] sw_digit;
  logic [3:0] keys_n;
  logic [7:0] entry_value;
  logic       entry_active;
  logic [1:0] digit_count;
  logic       err;
  logic [7:0] out_value;
  logic       out_valid;
  logic       out_ready;

  int checks = 0;
  int passes = 0;
  int vc;
  logic vc_clr;

  always #5 clk = ~clk;

  num_entry #(.DEBOUNCE_CYCLES(4)) dut (
    .clk(clk),
    .reset(reset),
    .sw_digit(sw_digit),
    .key_digit_n(keys_n[0]),
    .key_sign_n(keys_n[1]),
    .key_enter_n(keys_n[2]),
    .key_clear_n(keys_n[3]),
    .entry_value(entry_value),
    .entry_active(entry_active),
    .digit_count(digit_count),
    .err(err),
    .out_value(out_value),
    .out_valid(out_valid),
    .out_ready(out_ready)
  );

  // Counts cycles with out_valid high.
  always @(posedge clk) begin
    if (vc_clr) vc <= 0;
    else if (out_valid) vc <= vc + 1;
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
  endtask

  task automatic press(input logic [3:0] m);
    @(negedge clk);
    keys_n = ~m;
    repeat (12) @(negedge clk);
    keys_n = 4'hF;
    repeat (12) @(negedge clk);
  endtask

  task automatic digit(input logic [3:0] d);
    sw_digit = d;
    press(K_DIGIT);
  endtask

  initial begin
    reset     = 1'b1;
    sw_digit  = 4'd0;
    keys_n    = 4'hF;
    out_ready = 1'b1;
    vc_clr    = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_entry_value", entry_value, 8'h00);
    chk("rst_entry_active", 8'(entry_active), 8'h00);
    chk("rst_digit_count", 8'(digit_count), 8'h00);
    chk("rst_err", 8'(err), 8'h00);
    chk("rst_out_value", out_value, 8'h00);
    chk("rst_out_valid", 8'(out_valid), 8'h00);
    repeat (10) @(negedge clk);

    // single digit commit
    digit(4'd5);
    chk("d5_value", entry_value, 8'h05);
    chk("d5_active", 8'(entry_active), 8'h01);
    chk("d5_count", 8'(digit_count), 8'h01);
    vc_clr = 1'b0;
    press(K_ENTER);
    chk("d5_out_value", out_value, 8'h05);
    chk("d5_valid_cycles", 8'(vc), 8'h01);
    chk("d5_valid_low", 8'(out_valid), 8'h00);
    chk("d5_idle_count", 8'(digit_count), 8'h00);
    chk("d5_idle_value", entry_value, 8'h00);
    vc_clr = 1'b1;

    // 7, 3, sign -> -73
    digit(4'd7);
    chk("d7_value", entry_value, 8'h07);
    digit(4'd3);
    chk("d73_value", entry_value, 8'h49);
    press(K_SIGN);
    chk("neg73_value", entry_value, 8'hB7);
    press(K_ENTER);
    chk("neg73_out", out_value, 8'hB7);

    // -128 boundary
    press(K_SIGN);
    chk("sign_idle_value", entry_value, 8'h00);
    digit(4'd1);
    chk("neg1_value", entry_value, 8'hFF);
    digit(4'd2);
    chk("neg12_value", entry_value, 8'hF4);
    digit(4'd8);
    chk("neg128_value", entry_value, 8'h80);
    chk("neg128_err", 8'(err), 8'h00);
    press(K_SIGN);
    chk("neg128_sign_err", 8'(err), 8'h01);
    chk("neg128_sign_value", entry_value, 8'h80);
    press(K_CLEAR);
    chk("clr_err", 8'(err), 8'h00);
    chk("clr_value", entry_value, 8'h00);
    press(K_ENTER);
    chk("enter_idle_valid", 8'(out_valid), 8'h00);
    chk("enter_idle_err", 8'(err), 8'h00);
    digit(4'd1);
    digit(4'd2);
    digit(4'd8);
    chk("pos128_value", entry_value, 8'h0C);
    chk("pos128_err", 8'(err), 8'h01);
    chk("pos128_count", 8'(digit_count), 8'h02);
    press(K_CLEAR);

    // illegal BCD, fourth digit, glitch
    digit(4'd12);
    chk("bcd12_err", 8'(err), 8'h01);
    chk("bcd12_count", 8'(digit_count), 8'h00);
    chk("bcd12_value", entry_value, 8'h00);
    press(K_CLEAR);
    digit(4'd1);
    digit(4'd0);
    digit(4'd0);
    chk("d100_value", entry_value, 8'h64);
    chk("d100_count", 8'(digit_count), 8'h03);
    digit(4'd5);
    chk("d4th_err", 8'(err), 8'h01);
    chk("d4th_value", entry_value, 8'h64);
    press(K_CLEAR);
    digit(4'd9);
    @(negedge clk);
    keys_n[0] = 1'b0;
    repeat (2) @(negedge clk);
    keys_n[0] = 1'b1;
    repeat (20) @(negedge clk);
    chk("glitch_count", 8'(digit_count), 8'h01);
    chk("glitch_value", entry_value, 8'h09);
    press(K_CLEAR);

    // back-pressure in DONE
    digit(4'd4);
    digit(4'd2);
    out_ready = 1'b0;
    press(K_ENTER);
    chk("bp_valid", 8'(out_valid), 8'h01);
    chk("bp_out", out_value, 8'h2A);
    repeat (20) @(negedge clk);
    digit(4'd1);
    chk("bp_valid_held", 8'(out_valid), 8'h01);
    chk("bp_out_held", out_value, 8'h2A);
    chk("bp_digit_ignored", entry_value, 8'h2A);
    chk("bp_count_held", 8'(digit_count), 8'h02);
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("hs_valid", 8'(out_valid), 8'h00);
    chk("hs_count", 8'(digit_count), 8'h00);
    chk("hs_active", 8'(entry_active), 8'h00);
    chk("hs_out_kept", out_value, 8'h2A);

    // clear beats digit
    digit(4'd5);
    sw_digit = 4'd3;
    press(K_CLEAR | K_DIGIT);
    chk("clr_digit_value", entry_value, 8'h00);
    chk("clr_digit_count", 8'(digit_count), 8'h00);

    // reset mid-entry with a key held through it
    digit(4'd4);
    digit(4'd2);
    @(negedge clk);
    keys_n[0] = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("mid_rst_value", entry_value, 8'h00);
    chk("mid_rst_count", 8'(digit_count), 8'h00);
    chk("mid_rst_out", out_value, 8'h00);
    chk("mid_rst_valid", 8'(out_valid), 8'h00);
    repeat (20) @(negedge clk);
    chk("held_no_pulse", 8'(digit_count), 8'h00);
    keys_n = 4'hF;
    repeat (12) @(negedge clk);
    digit(4'd6);
    chk("after_rst_digit", entry_value, 8'h06);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/num_entry.md
# num_entry

Pushbutton/switch number-entry block for the calculator datapath. It builds a signed 8-bit two's-complement operand from decimal digits set on the slide switches, committed with pushbuttons. It exposes the live value for the 7-segment display path and hands the committed operand to the ALU stage through a valid/ready handshake. All button inputs are synchronised and debounced internally.

## Interface
- `DEBOUNCE_CYCLES`, default 500000: cycles a synchronised button level must hold stable before it is accepted (10 ms at 50 MHz).
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high reset.
- `sw_digit`  in  4  BCD digit from the switches; values 10–15 are illegal.
- `key_digit_n`  in  1  active-low raw button: append `sw_digit`.
- `key_sign_n`  in  1  active-low raw button: toggle the sign.
- `key_enter_n`  in  1  active-low raw button: commit the entry.
- `key_clear_n`  in  1  active-low raw button: abandon the entry.
- `entry_value`  out  8  live two's-complement entry, driven to the display block.
- `entry_active`  out  1  high when at least one digit has been accepted.
- `digit_count`  out  2  number of accepted digits, 0–3.
- `err`  out  1  sticky; set by a rejected digit or rejected sign toggle; cleared by clear, commit handshake or reset.
- `out_value`  out  8  committed operand.
- `out_valid`  out  1  committed operand is available.
- `out_ready`  in  1  consumer accepts `out_value`.

## Operation
- Each key passes through a 2-FF synchroniser and a debounce counter. Once the debounced level changes, the press (high→low) edge produces exactly one 1-cycle pulse. The release edge produces nothing.
- Internal state: `mag` is 8-bit unsigned, `neg` is 1 bit, `digit_count` is 2 bits.
- `entry_value` = `neg` ? (~mag + 1) : mag, truncated to 8 bits.
- FSM:
  - IDLE: `mag`=0, `digit_count`=0.
  - ENTRY: at least one digit accepted.
  - DONE: `out_valid`=1.
- Digit pulse (IDLE/ENTRY):
  - Compute `cand` = mag*10 + sw_digit in 12 bits.
  - Reject and set `err` if `sw_digit` > 9, `digit_count` = 3, or `cand` > (`neg` ? 128 : 127).
  - Otherwise `mag` ← `cand`, `digit_count`++, and go to ENTRY.
- Sign pulse (IDLE/ENTRY): `neg` toggles. If `neg`=1 and `mag`=128, the toggle is rejected, `err` is set, and `neg` stays 1.
- Enter pulse:
  - In ENTRY: `out_value` ← `entry_value`, `out_valid` ← 1, go to DONE.
  - In IDLE: ignored (not an error).
- DONE: digit, sign and enter pulses are ignored. When `out_valid` && `out_ready`: `out_valid` ← 0, `mag`, `neg`, `digit_count` and `err` are cleared, go to IDLE.
- Clear pulse (any state): `mag`, `neg`, `digit_count`, `err` and `out_valid` are cleared, go to IDLE. `out_value` holds its last value.
- Simultaneous pulses, resolved by priority: clear > enter > sign > digit. Only the highest-priority pulse acts in a given cycle.
- Reset values:
  - `entry_value`=0, `entry_active`=0, `digit_count`=0, `err`=0, `out_value`=0, `out_valid`=0.
  - FSM in IDLE, `neg`=0.
  - Debounced key levels = released, counters = 0.
- Reset mid-entry or in DONE discards everything. No press pulse is generated while a key is held through reset release; the key must be released and pressed again.

## Timing
- Key fall to pulse: 2 synchroniser cycles + `DEBOUNCE_CYCLES` + 1.
- Pulse to state/output update: 1 cycle. All outputs are registered.
- A glitch shorter than `DEBOUNCE_CYCLES` restarts the counter and produces no pulse.
- `out_valid` rises 1 cycle after the enter pulse.
- `out_valid` falls in the cycle after the handshake. It may be held indefinitely while `out_ready`=0, and `out_value` is stable throughout.
- An `out_ready` assertion while `out_valid`=0 has no effect.

## Structure
- Shared package `calc_pkg` holds:
  - state encoding: IDLE, ENTRY, DONE;
  - constants `MAX_POS`=127, `MAX_NEG_MAG`=128, `MAX_DIGITS`=3;
  - BCD limit 9.
- Sub-module `btn_debounce` (parameter `DEBOUNCE_CYCLES`; ports `clk`, `reset`, `key_n`, `press`) contains the synchroniser, counter and edge pulse. It is instantiated four times.
- `num_entry` contains the FSM, the accumulator and the handshake register.

## Test plan
All scenarios run with `DEBOUNCE_CYCLES`=4 and `out_ready`=1 unless stated otherwise.
- `sw_digit`=5, digit press, enter press → `out_value`=0x05, `out_valid` high for 1 cycle, then IDLE.
- Digits 7, 3, sign press, enter press → `entry_value` 0x07, 0x49, 0xB7; `out_value`=0xB7 (−73).
- Sign, then digits 1, 2, 8 → 0x80, `err`=0. A further sign press is rejected: `err`=1, value stays 0x80. Digits 1, 2, 8 with positive sign → 8 rejected, value 0x0C, `err`=1.
- `sw_digit`=12 press → ignored, `err`=1. A fourth digit after "100" is rejected. A 2-cycle glitch on `key_digit_n` produces no change.
- Enter 42 with `out_ready`=0 for 20 cycles → `out_valid` and `out_value`=0x2A held, digit presses ignored. `out_ready`=1 → handshake, IDLE.
- Clear and digit pressed on the same cycle → clear wins, value 0. `reset` asserted mid-entry → all outputs 0, and a key held through reset yields no pulse.
